// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: FSM state encoding, pixel word layout and the
// default timing thresholds. The transmit side uses the same constants.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_ERR  = 2'd2
  } rx_state_t;

  localparam int PIXEL_W = 24;
  typedef logic [PIXEL_W-1:0] pixel_t;

  // Bit offsets of the colour fields inside a {G,R,B} pixel word
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  // Timing thresholds in 12 MHz clk cycles
  localparam int DEF_BIT_THRESH   = 8;
  localparam int DEF_MIN_HIGH     = 2;
  localparam int DEF_MAX_HIGH     = 30;
  localparam int DEF_RESET_CYCLES = 600;
  localparam int DEF_IDX_W        = 6;

  // Assemble a pixel word from its colour channels
  function automatic pixel_t pack_grb(input logic [7:0] g, input logic [7:0] r,
                                      input logic [7:0] b);
    pixel_t p;
    p = '0;
    p[G_LSB +: 8] = g;
    p[R_LSB +: 8] = r;
    p[B_LSB +: 8] = b;
    return p;
  endfunction

endpackage

// File: rtl/ws2812b_rx_sync_edge.sv
// sync_edge block: two-flop synchronizer for an asynchronous input plus
// single-cycle rise/fall pulses derived from the synchronized level.
module ws2812b_rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchronizer chain plus one delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~sync_d;
  assign fall  = ~sync & sync_d;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: decodes the single-wire NRZ stream into 24-bit {G,R,B}
// pixel words with a per-frame index and frame-boundary strobes.
// Optional macro WS2812B_RX_FORWARD_EN adds a daisy-chain forwarding output
// 'dout' that repeats the line once the first pixel of a frame is consumed.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int BIT_THRESH   = DEF_BIT_THRESH,
  parameter int MIN_HIGH     = DEF_MIN_HIGH,
  parameter int MAX_HIGH     = DEF_MAX_HIGH,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int IDX_W        = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  output logic [IDX_W-1:0]   pixel_index,
  output logic               frame_done,
  output logic               partial,
  output logic               bit_error
`ifdef WS2812B_RX_FORWARD_EN
  ,
  output logic               dout
`endif
);

  localparam int LOW_W = $clog2(RESET_CYCLES + 1);
  localparam int HI_W  = $clog2(MAX_HIGH + 1);

  // The high counter starts at 0 on the rising edge, so a pulse of N cycles
  // shows a count of N-1 when its falling edge is seen.
  localparam logic [LOW_W-1:0] LOW_LAST  = LOW_W'(RESET_CYCLES - 1);
  localparam logic [LOW_W-1:0] LOW_SAT   = LOW_W'(RESET_CYCLES);
  localparam logic [HI_W-1:0]  HI_MIN    = HI_W'(MIN_HIGH - 1);
  localparam logic [HI_W-1:0]  HI_ONE    = HI_W'(BIT_THRESH - 1);
  localparam logic [HI_W-1:0]  HI_ERR    = HI_W'(MAX_HIGH - 2);
  localparam logic [4:0]       LAST_BIT  = 5'd23;

  logic             din_sync;
  logic             din_rise;
  logic             din_fall;

  rx_state_t        state;
  logic [LOW_W-1:0] low_cnt;
  logic [HI_W-1:0]  hi_cnt;
  logic [4:0]       bit_cnt;
  pixel_t           shreg;
  logic             emit_pending;
  logic [IDX_W-1:0] next_index;

  logic             frame_latch;
  logic             bit_accept;
  logic             word_done;

  ws2812b_rx_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .level (din_sync),
    .rise  (din_rise),
    .fall  (din_fall)
  );

  assign frame_latch = (state == S_LOW) && (low_cnt == LOW_LAST);
  assign bit_accept  = (state == S_HIGH) && din_fall && (hi_cnt >= HI_MIN);
  assign word_done   = bit_accept && (bit_cnt == LAST_BIT);

  // Pulse-width decoder, pixel assembly and frame latching
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LOW;
      low_cnt      <= '0;
      hi_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      emit_pending <= 1'b0;
      next_index   <= '0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      partial      <= 1'b0;
      bit_error    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;

      if (emit_pending) begin
        emit_pending <= 1'b0;
        pixel_data   <= shreg;
        pixel_valid  <= 1'b1;
        pixel_index  <= next_index;
        next_index   <= next_index + 1'b1;
      end

      case (state)
        S_LOW: begin
          if (frame_latch) begin
            low_cnt     <= LOW_SAT;
            frame_done  <= 1'b1;
            partial     <= (bit_cnt != 5'd0);
            bit_cnt     <= '0;
            pixel_index <= '0;
            next_index  <= '0;
            bit_error   <= 1'b0;
          end else if (low_cnt != LOW_SAT) begin
            low_cnt <= low_cnt + 1'b1;
          end
          if (din_rise) begin
            state  <= S_HIGH;
            hi_cnt <= '0;
          end
        end

        S_HIGH: begin
          if (din_fall) begin
            state <= S_LOW;
            if (bit_accept) begin
              shreg   <= {shreg[PIXEL_W-2:0], (hi_cnt >= HI_ONE)};
              low_cnt <= '0;
              if (word_done) begin
                bit_cnt      <= '0;
                emit_pending <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else if (hi_cnt == HI_ERR) begin
            bit_error <= 1'b1;
            bit_cnt   <= '0;
            state     <= S_ERR;
          end else begin
            hi_cnt <= hi_cnt + 1'b1;
          end
        end

        S_ERR: begin
          if (!din_sync) begin
            state   <= S_LOW;
            low_cnt <= '0;
          end
        end

        default: state <= S_LOW;
      endcase
    end
  end

`ifdef WS2812B_RX_FORWARD_EN
  logic fwd_active;

  // Forwarding opens once this node has consumed its own pixel and closes at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_active <= 1'b0;
    end else if (frame_latch) begin
      fwd_active <= 1'b0;
    end else if (word_done) begin
      fwd_active <= 1'b1;
    end
  end

  assign dout = fwd_active & din_sync;
`endif

endmodule
